// File: rtl/lb_reg_responder.sv
// Local-bus register target behind the ethergate memory gateway: 8 R/W words, 4 sampled RO words,
// 3 transaction counters and an ID word, with a fixed read latency. Optional lock register: LB_RESP_LOCK_EN.
module lb_reg_responder #(
  parameter logic [23:0] base      = 24'h000000,
  parameter int          read_pipe = 3,
  parameter logic [31:0] id_word   = 32'h4C425250
) (
  input  logic         lb_clk,
  input  logic         rst_n,
  input  logic [23:0]  lb_addr,
  input  logic         lb_control_strobe,
  input  logic         lb_control_rd,
  input  logic [31:0]  lb_data,
  output logic [31:0]  lb_out,
  input  logic [127:0] ro_data,
  output logic [255:0] cfg_regs,
  output logic [7:0]   cfg_stb
);

  logic [3:0]        offset;
  logic              hit, miss, rd_hit, wr_hit, rd_stb, locked;
  logic [7:0][31:0]  cfg_q, cfg_d;
  logic [7:0]        stb_q, stb_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [31:0]       id_rdata, rdata;

  assign offset = lb_addr[3:0];
  assign hit    = lb_control_strobe && (lb_addr[23:4] == base[23:4]);
  assign miss   = lb_control_strobe && !hit;
  assign rd_hit = hit && lb_control_rd;
  assign wr_hit = hit && !lb_control_rd;
  assign rd_stb = lb_control_strobe && lb_control_rd;

`ifdef LB_RESP_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (wr_hit && offset == 4'd15) begin
      if (lb_data == 32'hA5A50001) lock_d = 1'b1;
      else if (lb_data == 32'hA5A50000) lock_d = 1'b0;
    end
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end

  assign locked   = lock_q;
  assign id_rdata = {id_word[31:1], lock_q};
`else
  assign locked   = 1'b0;
  assign id_rdata = id_word;
`endif

  // Counter clears take priority, and a clearing write is never itself counted.
  always_comb begin
    cfg_d      = cfg_q;
    stb_d      = '0;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (wr_hit && !offset[3] && !locked) begin
      cfg_d[offset[2:0]] = lb_data;
      stb_d[offset[2:0]] = 1'b1;
    end
    if (wr_hit && offset == 4'd12)
      wr_cnt_d = '0;
    else if (wr_hit && offset != 4'd13 && offset != 4'd14)
      wr_cnt_d = wr_cnt_q + 16'd1;
    if (wr_hit && offset == 4'd13)
      rd_cnt_d = '0;
    else if (rd_hit)
      rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_hit && offset == 4'd14)
      miss_cnt_d = '0;
    else if (miss)
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        4'd8, 4'd9, 4'd10, 4'd11: rdata = ro_data[32*offset[1:0] +: 32];
        4'd12:                    rdata = {16'd0, wr_cnt_q};
        4'd13:                    rdata = {16'd0, rd_cnt_q};
        4'd14:                    rdata = {16'd0, miss_cnt_q};
        4'd15:                    rdata = id_rdata;
        default:                  rdata = cfg_q[offset[2:0]];
      endcase
    end
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      stb_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      cfg_q      <= cfg_d;
      stb_q      <= stb_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cfg_regs = cfg_q;
  assign cfg_stb  = stb_q;

  // Read pipeline: stage k holds a result captured k+1 edges ago; the last stage drives lb_out
  // directly and hold_q keeps the most recent result between reads.
  logic [read_pipe-1:0] vld_q;
  logic [31:0]          dat_q [read_pipe];
  logic [31:0]          hold_q;

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      hold_q <= '0;
      for (int i = 0; i < read_pipe; i++) dat_q[i] <= '0;
    end else begin
      for (int i = read_pipe - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= rd_stb;
      dat_q[0] <= rdata;
      if (vld_q[read_pipe-1]) hold_q <= dat_q[read_pipe-1];
    end
  end

  assign lb_out = vld_q[read_pipe-1] ? dat_q[read_pipe-1] : hold_q;

endmodule

// File: tb/tb_lb_reg_responder.sv
// Randomized bench for lb_reg_responder against a transaction-level register model with a
// latency-tagged expected-read queue. Build with +define+LB_RESP_LOCK_EN to cover the lock register.
module tb_lb_reg_responder;

  localparam logic [23:0] BASE = 24'h000000;
  localparam int          RP   = 3;
  localparam logic [31:0] ID   = 32'h4C425250;

  logic         lb_clk = 1'b0;
  logic         rst_n  = 1'b0;
  logic [23:0]  lb_addr = '0;
  logic         lb_control_strobe = 1'b0;
  logic         lb_control_rd = 1'b0;
  logic [31:0]  lb_data = '0;
  logic [31:0]  lb_out;
  logic [127:0] ro_data = '0;
  logic [255:0] cfg_regs;
  logic [7:0]   cfg_stb;

  lb_reg_responder #(.base(BASE), .read_pipe(RP), .id_word(ID)) dut (
    .lb_clk(lb_clk), .rst_n(rst_n), .lb_addr(lb_addr),
    .lb_control_strobe(lb_control_strobe), .lb_control_rd(lb_control_rd),
    .lb_data(lb_data), .lb_out(lb_out), .ro_data(ro_data),
    .cfg_regs(cfg_regs), .cfg_stb(cfg_stb)
  );

  // clock / reset
  always #5 lb_clk = ~lb_clk;

  // reference model state
  logic [31:0] cfg_m [8];
  int          wr_m, rd_m, miss_m;
  logic        lock_m;
  logic [31:0] exp_q [$];
  int          due_q [$];
  logic [31:0] exp_out;
  logic [7:0]  exp_stb;
  int          cyc;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [255:0] cfg_packed();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = cfg_m[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) cfg_m[k] = '0;
    wr_m = 0; rd_m = 0; miss_m = 0; lock_m = 1'b0;
    exp_q.delete(); due_q.delete();
    exp_out = '0; exp_stb = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] off, input logic [127:0] ro);
    if (off < 8)        return cfg_m[off[2:0]];
    else if (off < 12)  return ro[32*(off-8) +: 32];
    else if (off == 12) return 32'(wr_m);
    else if (off == 13) return 32'(rd_m);
    else if (off == 14) return 32'(miss_m);
`ifdef LB_RESP_LOCK_EN
    return {ID[31:1], lock_m};
`else
    return ID;
`endif
  endfunction

  // One transaction per cycle: check outputs of the current cycle, then drive and model the next strobe.
  task automatic step(input logic s, input logic r, input logic [23:0] a, input logic [31:0] d,
                      input logic [127:0] ro);
    logic       hit;
    logic [3:0] off;
    @(negedge lb_clk);
    cyc++;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      exp_out = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    check("lb_out", {224'd0, lb_out}, {224'd0, exp_out});
    check("cfg_regs", cfg_regs, cfg_packed());
    check("cfg_stb", {248'd0, cfg_stb}, {248'd0, exp_stb});

    lb_control_strobe = s; lb_control_rd = r; lb_addr = a; lb_data = d; ro_data = ro;

    hit = s && (a[23:4] == BASE[23:4]);
    off = a[3:0];
    exp_stb = '0;
    if (s && r) begin
      exp_q.push_back(hit ? model_read(off, ro) : 32'd0);
      due_q.push_back(cyc + RP);
    end
    if (s && !hit) miss_m = (miss_m + 1) % 65536;
    else if (hit && r) rd_m = (rd_m + 1) % 65536;
    else if (hit) begin
      if (off == 12) wr_m = 0;
      else if (off == 13) rd_m = 0;
      else if (off == 14) miss_m = 0;
      else begin
        wr_m = (wr_m + 1) % 65536;
        if (off < 8 && !lock_m) begin
          cfg_m[off[2:0]] = d;
          exp_stb = 8'(1 << off);
        end
`ifdef LB_RESP_LOCK_EN
        if (off == 15 && d == 32'hA5A50001) lock_m = 1'b1;
        if (off == 15 && d == 32'hA5A50000) lock_m = 1'b0;
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'($urandom), $urandom, '0);
  endtask

  task automatic do_reset();
    @(negedge lb_clk);
    cyc++;
    lb_control_strobe = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_lb_out", {224'd0, lb_out}, 256'd0);
    check("rst_cfg", cfg_regs, 256'd0);
    check("rst_stb", {248'd0, cfg_stb}, 256'd0);
    repeat (2) begin @(negedge lb_clk); cyc++; end
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return {BASE[23:4] + 20'($urandom_range(1, 15)), 4'($urandom)};
    return {BASE[23:4], 4'($urandom)};
  endfunction

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    model_clear();
    do_reset();

    // ID read at fixed latency
    step(1'b1, 1'b1, BASE | 24'd15, '0, '0);
    idle(RP + 1);

    // write then immediate read-back, then write count
    step(1'b1, 1'b0, BASE | 24'd2, 32'hDEADBEEF, '0);
    step(1'b1, 1'b1, BASE | 24'd2, '0, '0);
    step(1'b1, 1'b1, BASE | 24'd12, '0, '0);
    idle(RP + 1);

    // back-to-back RO reads
    for (int k = 8; k < 12; k++)
      step(1'b1, 1'b1, BASE | 24'(k), '0, {32'd4, 32'd3, 32'd2, 32'd1});
    idle(RP + 1);

    // misses, miss count, miss-count clear
    step(1'b1, 1'b1, 24'h000010 ^ BASE, '0, '0);
    step(1'b1, 1'b1, 24'h000010 ^ BASE, '0, '0);
    step(1'b1, 1'b1, BASE | 24'd14, '0, '0);
    step(1'b1, 1'b0, BASE | 24'd14, 32'h12345678, '0);
    step(1'b1, 1'b1, BASE | 24'd14, '0, '0);
    idle(RP + 1);

    // reset one cycle after a read strobe
    step(1'b1, 1'b1, BASE | 24'd2, '0, '0);
    do_reset();
    idle(RP + 2);

`ifdef LB_RESP_LOCK_EN
    step(1'b1, 1'b0, BASE | 24'd0, 32'd9, '0);
    step(1'b1, 1'b0, BASE | 24'd15, 32'hA5A50001, '0);
    step(1'b1, 1'b0, BASE | 24'd0, 32'd5, '0);
    step(1'b1, 1'b1, BASE | 24'd15, '0, '0);
    step(1'b1, 1'b0, BASE | 24'd12, 32'd0, '0);
    step(1'b1, 1'b0, BASE | 24'd15, 32'hA5A50000, '0);
    step(1'b1, 1'b1, BASE | 24'd15, '0, '0);
    idle(RP + 1);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = $urandom;
`ifdef LB_RESP_LOCK_EN
      if ($urandom_range(0, 7) == 0) d = {31'h52D28000, 1'($urandom)};
`endif
      step(1'($urandom_range(0, 9) < 7), 1'($urandom), rand_addr(), d,
           {$urandom, $urandom, $urandom, $urandom});
    end
    idle(RP + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
